// File: rtl/xsm_frame_pkg.sv
// Shared types and helpers for the XSM frame assembler.
// Pure definitions; no latency.
// No flow control of its own.
package xsm_frame_pkg;

    localparam int NUM_CH = 4;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [0:0] {WAIT_CH0, COLLECT} fsm_state_t;

    // One bit of a CRC-8, MSB-first, non-reflected.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/xsm_frame_fifo.sv
// Synchronous show-ahead FIFO with flush; head is visible on dout while !empty.
// Latency: a push is visible at dout one cycle later when the FIFO was empty.
// Backpressure: push is taken when not full, or when full with a simultaneous pop.
module xsm_frame_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/xsm_frame_assembler.sv
// Assembles ch0..ch3 capture samples into timestamped frames; optional CRC-8 via XSM_FRAME_CRC_EN.
// Latency: frame_valid rises the cycle after the ch3 accept when the frame FIFO was empty.
// Backpressure: frames queue in the FIFO under frame_ready=0; a push into a full FIFO is dropped and counted.
module xsm_frame_assembler
    import xsm_frame_pkg::*;
#(
    parameter int SAMPLE_WIDTH  = 16,
    parameter int TS_WIDTH      = 48,
    parameter int FIFO_DEPTH    = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [TS_WIDTH-1:0]           mono_counter,
    input  logic [SAMPLE_WIDTH-1:0]       sample_data,
    input  logic [1:0]                    channel_id,
    input  logic                          sample_valid,
    input  logic                          flush,
    output logic                          frame_valid,
    input  logic                          frame_ready,
    output logic [NUM_CH*SAMPLE_WIDTH-1:0] frame_data,
    output logic [TS_WIDTH-1:0]           frame_ts,
`ifdef XSM_FRAME_CRC_EN
    output logic [7:0]                    frame_crc,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [ERR_CNT_WIDTH-1:0]      seq_err_cnt,
    output logic [ERR_CNT_WIDTH-1:0]      ovf_cnt
);

    localparam int DATA_W = NUM_CH * SAMPLE_WIDTH;

    typedef struct packed {
`ifdef XSM_FRAME_CRC_EN
        logic [7:0]          crc;
`endif
        logic [TS_WIDTH-1:0] ts;
        logic [DATA_W-1:0]   data;
    } frame_t;

    fsm_state_t              state, state_nxt;
    logic                    sv_d1;
    logic                    accept;
    logic [1:0]              exp_ch;
    logic [SAMPLE_WIDTH-1:0] smp0, smp1, smp2;
    logic [TS_WIDTH-1:0]     ts_q;
    logic                    store_ch0, store_nxt, push_vld, seq_err;
    logic                    fifo_full, fifo_empty;
    frame_t                  frm_in, frm_out;

    // A held valid pulse counts once: only its rising edge is an accept.
    assign accept = sample_valid & ~sv_d1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_CH0;
            sv_d1 <= 1'b0;
        end else begin
            state <= state_nxt;
            sv_d1 <= sample_valid;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = WAIT_CH0;
        end else if (accept) begin
            case (state)
                WAIT_CH0: if (channel_id == 2'd0) state_nxt = COLLECT;
                COLLECT: begin
                    if (channel_id == exp_ch) begin
                        if (exp_ch == 2'd3) state_nxt = WAIT_CH0;
                    end else if (channel_id != 2'd0) begin
                        state_nxt = WAIT_CH0;
                    end
                end
                default: state_nxt = WAIT_CH0;
            endcase
        end
    end

    always_comb begin
        store_ch0 = 1'b0;
        store_nxt = 1'b0;
        push_vld  = 1'b0;
        seq_err   = 1'b0;
        if (accept && !flush) begin
            case (state)
                WAIT_CH0: begin
                    if (channel_id == 2'd0) store_ch0 = 1'b1;
                    else                    seq_err   = 1'b1;
                end
                COLLECT: begin
                    if (channel_id == exp_ch) begin
                        if (exp_ch == 2'd3) push_vld  = 1'b1;
                        else                store_nxt = 1'b1;
                    end else begin
                        seq_err   = 1'b1;
                        store_ch0 = (channel_id == 2'd0);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_ch <= 2'd0;
            ts_q   <= '0;
            smp0   <= '0;
            smp1   <= '0;
            smp2   <= '0;
        end else if (store_ch0) begin
            smp0   <= sample_data;
            ts_q   <= mono_counter;
            exp_ch <= 2'd1;
        end else if (store_nxt) begin
            if (exp_ch == 2'd1) smp1 <= sample_data;
            else                smp2 <= sample_data;
            exp_ch <= exp_ch + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_err_cnt <= '0;
            ovf_cnt     <= '0;
        end else begin
            if (seq_err && seq_err_cnt != '1)
                seq_err_cnt <= seq_err_cnt + ERR_CNT_WIDTH'(1);
            if (push_vld && fifo_full && !(frame_valid && frame_ready) && ovf_cnt != '1)
                ovf_cnt <= ovf_cnt + ERR_CNT_WIDTH'(1);
        end
    end

    // ch3 goes straight from the input into the pushed frame.
    assign frm_in.data = {sample_data, smp2, smp1, smp0};
    assign frm_in.ts   = ts_q;

`ifdef XSM_FRAME_CRC_EN
    logic [TS_WIDTH+DATA_W-1:0] crc_bits;
    logic [7:0]                 crc_calc;

    assign crc_bits = {ts_q, frm_in.data};

    always_comb begin
        crc_calc = 8'h00;
        for (int i = TS_WIDTH + DATA_W - 1; i >= 0; i--)
            crc_calc = crc8_update(crc_calc, crc_bits[i]);
    end

    assign frm_in.crc = crc_calc;
    assign frame_crc  = frm_out.crc;
`endif

    xsm_frame_fifo #(
        .WIDTH ($bits(frame_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push_vld),
        .din   (frm_in),
        .full  (fifo_full),
        .pop   (frame_ready),
        .dout  (frm_out),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign frame_valid = ~fifo_empty;
    assign frame_data  = frm_out.data;
    assign frame_ts    = frm_out.ts;

endmodule

// File: tb/tb_xsm_frame_assembler.sv
// Scoreboard bench for xsm_frame_assembler: expected frames queued at stimulus, compared on pop.
module tb_xsm_frame_assembler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] mono_counter = '0;
    logic [15:0] sample_data = '0;
    logic [1:0]  channel_id = '0;
    logic        sample_valid = 1'b0;
    logic        flush = 1'b0;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic [63:0] frame_data;
    logic [47:0] frame_ts;
    logic [2:0]  fifo_level;
    logic [7:0]  seq_err_cnt;
    logic [7:0]  ovf_cnt;
`ifdef XSM_FRAME_CRC_EN
    logic [7:0]  frame_crc;
`endif

    typedef struct {
        logic [47:0] ts;
        logic [63:0] data;
        logic [7:0]  crc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    xsm_frame_assembler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mono_counter (mono_counter),
        .sample_data  (sample_data),
        .channel_id   (channel_id),
        .sample_valid (sample_valid),
        .flush        (flush),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_data   (frame_data),
        .frame_ts     (frame_ts),
`ifdef XSM_FRAME_CRC_EN
        .frame_crc    (frame_crc),
`endif
        .fifo_level   (fifo_level),
        .seq_err_cnt  (seq_err_cnt),
        .ovf_cnt      (ovf_cnt)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Byte-wise CRC-8/0x07 over {ts, data}, MSB first.
    function automatic logic [7:0] ref_crc(input logic [111:0] bits);
        logic [7:0] c;
        c = 8'h00;
        for (int b = 13; b >= 0; b--) begin
            c ^= bits[b*8 +: 8];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    task automatic push_exp(input logic [47:0] ts, input logic [63:0] data);
        exp_t e;
        e.ts   = ts;
        e.data = data;
        e.crc  = ref_crc({ts, data});
        exp_q.push_back(e);
    endtask

    // Scoreboard: compare on pop, and check head stability while stalled.
    always @(negedge clk) begin
        if (rst_n && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("frame_data", frame_data, e.data);
                check("frame_ts", frame_ts, e.ts);
`ifdef XSM_FRAME_CRC_EN
                check("frame_crc", frame_crc, e.crc);
`endif
            end
        end else if (rst_n && frame_valid && !frame_ready && exp_q.size() != 0) begin
            check("stall_data", frame_data, exp_q[0].data);
            check("stall_ts", frame_ts, exp_q[0].ts);
        end
    end

    task automatic send(input logic [1:0] ch, input logic [15:0] d, input logic [47:0] ts, input int hold);
        @(posedge clk); #1;
        sample_valid = 1'b1;
        channel_id   = ch;
        sample_data  = d;
        mono_counter = ts;
        repeat (hold) @(posedge clk);
        #1 sample_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] ts, input logic [63:0] d, input int hold, input bit expect_push);
        send(2'd0, d[15:0],  ts,      hold);
        send(2'd1, d[31:16], ts + 11, hold);
        send(2'd2, d[47:32], ts + 22, hold);
        if (expect_push) push_exp(ts, d);
        send(2'd3, d[63:48], ts + 33, hold);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(posedge clk); #1 frame_ready = 1'b1;
        while ((exp_q.size() != 0 || frame_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", n < 100, 1);
        frame_ready = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, frame_valid, 0);
        check({tag, "_level"}, fifo_level, 0);
        check({tag, "_seq"}, seq_err_cnt, 0);
        check({tag, "_ovf"}, ovf_cnt, 0);
        check({tag, "_data"}, frame_data, 0);
        check({tag, "_ts"}, frame_ts, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        rst_n = 1'b1;

        // Ordered stream with frame_valid latency
        send(2'd0, 16'h1111, 48'd100, 2);
        send(2'd1, 16'h2222, 48'd105, 2);
        send(2'd2, 16'h3333, 48'd110, 2);
        push_exp(48'd100, 64'h4444_3333_2222_1111);
        @(posedge clk); #1;
        sample_valid = 1'b1; channel_id = 2'd3; sample_data = 16'h4444; mono_counter = 48'd115;
        @(negedge clk) check("valid_before_push", frame_valid, 0);
        @(posedge clk);
        @(negedge clk) check("valid_after_push", frame_valid, 1);
        @(posedge clk); #1 sample_valid = 1'b0;
        check("level_one", fifo_level, 1);
        drain();

        // Back-pressure: 5 frames, 4 stored, 1 dropped
        for (int i = 0; i < 5; i++)
            send_frame(48'd1000 + 48'(i * 100), {16'hA000 + 16'(i), 16'hB000 + 16'(i),
                       16'hC000 + 16'(i), 16'hD000 + 16'(i)}, 1 + (i % 3), i < 4);
        check("bp_level", fifo_level, 4);
        check("bp_ovf", ovf_cnt, 1);
        drain();
        check("bp_level_after", fifo_level, 0);

        // Sequence errors
        send(2'd0, 16'h0001, 48'd300, 1);
        send(2'd1, 16'h0002, 48'd301, 1);
        send(2'd3, 16'h0003, 48'd302, 1);
        check("seq_skip", seq_err_cnt, 1);
        check("seq_no_push", fifo_level, 0);
        send(2'd2, 16'h0004, 48'd303, 2);
        check("seq_wait", seq_err_cnt, 2);
        send(2'd0, 16'h0010, 48'd500, 1);
        send(2'd1, 16'h0011, 48'd501, 1);
        send(2'd0, 16'h0020, 48'd600, 3);
        send(2'd1, 16'h0021, 48'd601, 1);
        send(2'd2, 16'h0022, 48'd602, 2);
        push_exp(48'd600, 64'h0023_0022_0021_0020);
        send(2'd3, 16'h0023, 48'd603, 1);
        check("seq_restart", seq_err_cnt, 3);
        check("seq_restart_level", fifo_level, 1);
        drain();

        // Full FIFO with simultaneous pop and push
        for (int i = 0; i < 4; i++)
            send_frame(48'd2000 + 48'(i), {4{16'h5500 + 16'(i)}}, 2, 1'b1);
        check("full_level", fifo_level, 4);
        send(2'd0, 16'h6600, 48'd2500, 1);
        send(2'd1, 16'h6611, 48'd2501, 1);
        send(2'd2, 16'h6622, 48'd2502, 1);
        push_exp(48'd2500, 64'h6633_6622_6611_6600);
        @(posedge clk); #1;
        sample_valid = 1'b1; channel_id = 2'd3; sample_data = 16'h6633; frame_ready = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0; frame_ready = 1'b0;
        check("full_pop_push_level", fifo_level, 4);
        check("full_pop_push_ovf", ovf_cnt, 1);
        drain();

        // Flush mid-frame with 2 frames queued
        send_frame(48'd3000, 64'h7777_7777_7777_7777, 1, 1'b1);
        send_frame(48'd3100, 64'h8888_8888_8888_8888, 1, 1'b1);
        send(2'd0, 16'h9990, 48'd3200, 1);
        send(2'd1, 16'h9991, 48'd3201, 1);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        exp_q.delete();
        check("flush_valid", frame_valid, 0);
        check("flush_level", fifo_level, 0);
        check("flush_seq_kept", seq_err_cnt, 3);
        check("flush_ovf_kept", ovf_cnt, 1);
        send_frame(48'd3300, 64'h0D0C_0B0A_0908_0706, 2, 1'b1);
        check("post_flush_level", fifo_level, 1);
        drain();

        // Asynchronous reset mid-frame with a frame queued
        send_frame(48'd4000, 64'h1234_5678_9ABC_DEF0, 1, 1'b1);
        send(2'd0, 16'hAAAA, 48'd4100, 1);
        send(2'd1, 16'hBBBB, 48'd4101, 1);
        #3 rst_n = 1'b0;
        #1 check_reset_vals("midreset");
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        send(2'd2, 16'hCCCC, 48'd4200, 1);
        check("reset_needs_ch0", seq_err_cnt, 1);
        check("reset_needs_ch0_level", fifo_level, 0);
        send_frame(48'd4300, 64'hFACE_B00C_0000_0001, 1, 1'b1);
        drain();

        // CRC corner frames (checked through the scoreboard in CRC builds)
        send_frame(48'd0, 64'd0, 1, 1'b1);
        send_frame(48'd0, 64'd1, 1, 1'b1);
        check("crc_level", fifo_level, 2);
        drain();
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
